// File: rtl/rcad_serial_ctrl.sv
// Serial adder sequencer: one shared 4-bit ripple slice, one nibble per clock.
// Optional macro RCAD_SUB_EN adds a 'sub' port for A-B (two's complement via ~B + 1).

module rcad (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[4];
endmodule

module rcad_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef RCAD_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, busy_q, done_q;

  logic [IDXW+1:0]  off;
  logic [3:0]       sl_s;
  logic             sl_c;

  assign off = {idx_q, 2'b00};

  rcad u_slice (
    .a_i (a_q[off +: 4]),
    .b_i (b_q[off +: 4]),
    .c_i (carry_q),
    .s_o (sl_s),
    .c_o (sl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
`ifdef RCAD_SUB_EN
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[off +: 4] <= sl_s;
          carry_q         <= sl_c;
          idx_q           <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            // top nibble: final carry is published on the same edge
            cout_q  <= sl_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_rcad_serial_ctrl.sv
// Directed bench for rcad_serial_ctrl (NIBBLES=4) with an expected-result queue.
module tb_rcad_serial_ctrl;
  logic        clk = 1'b0;
  logic        rst_s = 1'b1, start_s = 1'b0, cin_s = 1'b0, sub_s = 1'b0;
  logic [15:0] a_s = '0, b_s = '0;
  logic        busy_w, done_w, cout_w;
  logic [15:0] sum_w;
  int          tests = 0, fails = 0;
  logic [16:0] sbq[$];

  always #5 clk = ~clk;

  rcad_serial_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst_s),
    .start (start_s),
    .a     (a_s),
    .b     (b_s),
    .cin   (cin_s),
`ifdef RCAD_SUB_EN
    .sub   (sub_s),
`endif
    .busy  (busy_w),
    .done  (done_w),
    .sum   (sum_w),
    .cout  (cout_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the negedge where start is raised; checks land on cycles 1..5.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input logic noisy);
    logic [16:0] exp, got;
    logic [15:0] bb;
    logic        c0;
    @(negedge clk);
    a_s = a; b_s = b; cin_s = ci; sub_s = sb; start_s = 1'b1;
    bb = sb ? ~b : b;
    c0 = sb ? 1'b1 : ci;
    exp = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
    sbq.push_back(exp);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_s = noisy && (c >= 2);
      if (noisy) begin
        a_s = 16'($urandom); b_s = 16'($urandom); cin_s = 1'($urandom);
      end
      chk($sformatf("busy_c%0d", c), {31'd0, busy_w}, 32'd1);
      chk($sformatf("nodone_c%0d", c), {31'd0, done_w}, 32'd0);
    end
    @(negedge clk);
    start_s = noisy;
    chk("done_c5", {31'd0, done_w}, 32'd1);
    chk("idle_busy_c5", {31'd0, busy_w}, 32'd0);
    chk("sb_nonempty", sbq.size(), 32'd1);
    got = (sbq.size() > 0) ? sbq.pop_front() : 17'h1FFFF;
    chk("sum", {16'd0, sum_w}, {16'd0, got[15:0]});
    chk("cout", {31'd0, cout_w}, {31'd0, got[16]});
  endtask

  initial begin
    logic [15:0] held;
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {31'd0, busy_w}, 32'd0);
    chk("rst_done", {31'd0, done_w}, 32'd0);
    chk("rst_sum", {16'd0, sum_w}, 32'd0);
    chk("rst_cout", {31'd0, cout_w}, 32'd0);
    rst_s = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    // back-to-back: accepted in cycle 6 of the previous op
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

    // start pulsed during RUN/DONE with scrambled operands must be ignored
    run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b1);
    held = sum_w;
    @(negedge clk); start_s = 1'b0;
    @(negedge clk);
    chk("ignored_busy", {31'd0, busy_w}, 32'd0);
    chk("held_sum", {16'd0, sum_w}, 32'h0000B6B7);
    chk("held_sum_stable", {16'd0, sum_w}, {16'd0, held});

    // reset mid-operation
    @(negedge clk); a_s = 16'h0F0F; b_s = 16'h0101; cin_s = 1'b1; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    @(negedge clk); rst_s = 1'b1;
    @(negedge clk); rst_s = 1'b0;
    chk("mrst_busy", {31'd0, busy_w}, 32'd0);
    chk("mrst_done", {31'd0, done_w}, 32'd0);
    chk("mrst_sum", {16'd0, sum_w}, 32'd0);
    chk("mrst_cout", {31'd0, cout_w}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_nodone%0d", i), {31'd0, done_w}, 32'd0);
    end

    for (int i = 0; i < 4; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);

`ifdef RCAD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
